// File: rtl/rvm_mem_responder.sv
// On-chip word RAM responder for the core memory bus: byte-enabled writes,
// word reads, programmable wait states and address error reporting.
module rvm_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WAIT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_c_en,
    input  logic [3:0]        mem_b_en,
    input  logic [WAIT_W-1:0] cfg_wait,
    output logic [31:0]       mem_rdata,
    output logic              mem_error,
    output logic              mem_stall
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] cnt;
    logic [31:0]       cap_addr, cap_wdata;
    logic [3:0]        cap_b_en;
    logic [31:0]       mem_words [DEPTH];

    logic              accept, enter_resp;
    logic [31:0]       req_addr, req_wdata, offset;
    logic [3:0]        req_b_en;
    logic              req_err;
    logic [IDX_W-1:0]  idx;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        mem_stall  = 1'b0;
        case (state)
            S_IDLE: begin
                mem_stall = mem_c_en;
                if (mem_c_en) begin
                    accept = 1'b1;
                    if (cfg_wait != '0) begin
                        next_state = S_WAIT;
                    end else begin
                        next_state = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (cnt == '0) begin
                    next_state = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // A zero-wait access commits straight from IDLE, before the capture registers load.
    always_comb begin
        req_addr  = cap_addr;
        req_wdata = cap_wdata;
        req_b_en  = cap_b_en;
        if (state == S_IDLE) begin
            req_addr  = mem_addr;
            req_wdata = mem_wdata;
            req_b_en  = mem_b_en;
        end
        offset  = req_addr - BASE_ADDR;
        idx     = IDX_W'(offset >> 2);
        req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                  ({1'b0, req_addr} >= LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_b_en  <= '0;
        end else if (accept) begin
            cnt       <= cfg_wait - 1'b1;
            cap_addr  <= mem_addr;
            cap_wdata <= mem_wdata;
            cap_b_en  <= mem_b_en;
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= '0;
            mem_error <= 1'b0;
        end else if (enter_resp) begin
            if (req_err) begin
                mem_rdata <= '0;
                mem_error <= 1'b1;
            end else begin
                mem_error <= 1'b0;
                if (req_b_en == '0) begin
                    mem_rdata <= mem_words[idx];
                end
            end
        end else if (state == S_RESP) begin
            mem_error <= 1'b0;
        end
    end

    // Array has no reset; the reset term keeps a held-in-reset accept from writing.
    always_ff @(posedge clk) begin
        if (enter_resp && !req_err && req_b_en != '0 && !reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (req_b_en[i]) begin
                    mem_words[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rvm_mem_responder.sv
// Randomized self-checking bench for rvm_mem_responder against a word-array
// reference model with latency and error expectations derived from the bus rules.
module tb_rvm_mem_responder;

    localparam int unsigned DEPTH  = 64;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int unsigned WAIT_W = 4;

    logic              clk;
    logic              reset;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_c_en;
    logic [3:0]        mem_b_en;
    logic [WAIT_W-1:0] cfg_wait;
    logic [31:0]       mem_rdata;
    logic              mem_error;
    logic              mem_stall;

    rvm_mem_responder #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE),
        .WAIT_W   (WAIT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_c_en (mem_c_en),
        .mem_b_en (mem_b_en),
        .cfg_wait (cfg_wait),
        .mem_rdata(mem_rdata),
        .mem_error(mem_error),
        .mem_stall(mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_rd;
    bit          in_resp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned x;
        x = a;
        return ((x % 4) != 0) || (x < BASE) || (x >= longint'(BASE) + 4 * DEPTH);
    endfunction

    // One bus transaction; keep leaves c_en high through RESP so the next call
    // issues a back-to-back request, drop releases c_en once in the wait phase.
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] b, input int unsigned wt, input bit keep, input bit drop);
        int unsigned stalls;
        bit          bad;
        int unsigned idx;
        logic [31:0] exp_rd;
        mem_addr  = a;
        mem_wdata = w;
        mem_b_en  = b;
        cfg_wait  = WAIT_W'(wt);
        mem_c_en  = 1'b1;
        if (in_resp) @(negedge clk);
        in_resp = 1'b0;
        stalls  = 0;
        #1;
        while (mem_stall && stalls < 64) begin
            stalls++;
            if (drop && stalls == 2) mem_c_en = 1'b0;
            @(negedge clk);
            #1;
        end
        bad = addr_bad(a);
        idx = (a - BASE) >> 2;
        if (bad) begin
            exp_rd = 32'h0;
        end else if (b == 4'h0) begin
            exp_rd = model[idx];
        end else begin
            exp_rd = last_rd;
            for (int i = 0; i < 4; i++)
                if (b[i]) model[idx][8*i +: 8] = w[8*i +: 8];
        end
        last_rd = exp_rd;
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(wt + 1));
        chk({tag, ".error"}, {31'b0, mem_error}, {31'b0, bad});
        chk({tag, ".rdata"}, mem_rdata, exp_rd);
        if (keep) begin
            in_resp = 1'b1;
        end else begin
            mem_c_en = 1'b0;
            mem_b_en = 4'h0;
            @(negedge clk);
            #1;
            chk({tag, ".idle_stall_err"}, {30'b0, mem_stall, mem_error}, 32'h0);
            chk({tag, ".idle_rdata_hold"}, mem_rdata, exp_rd);
        end
    endtask

    task automatic pulse_reset(input string tag);
        mem_c_en = 1'b0;
        reset    = 1'b1;
        #1;
        chk({tag, ".stall"}, {31'b0, mem_stall}, 32'h0);
        chk({tag, ".rdata"}, mem_rdata, 32'h0);
        chk({tag, ".error"}, {31'b0, mem_error}, 32'h0);
        @(negedge clk);
        reset   = 1'b0;
        last_rd = 32'h0;
        in_resp = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  b;
        int unsigned r, wt;
        reset     = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_c_en  = 1'b0;
        mem_b_en  = '0;
        cfg_wait  = '0;
        in_resp   = 1'b0;
        last_rd   = '0;
        repeat (2) @(negedge clk);
        chk("reset.rdata", mem_rdata, 32'h0);
        chk("reset.err_stall", {30'b0, mem_stall, mem_error}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < int'(DEPTH); i++)
            txn("init", BASE + 32'(4 * i), $urandom, 4'hF, 0, 1'b0, 1'b0);

        txn("t1.write", 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 1'b0);
        txn("t1.read",  32'h10, 32'h0,         4'h0, 0, 1'b0, 1'b0);
        chk("t1.value", mem_rdata, 32'hDEAD_BEEF);
        txn("t2.write", 32'h10, 32'h0000_AA00, 4'b0010, 0, 1'b0, 1'b0);
        txn("t2.read",  32'h10, 32'h0,         4'h0, 0, 1'b0, 1'b0);
        chk("t2.value", mem_rdata, 32'hDEAD_AAEF);
        txn("t3.read_wait3", 32'h10, 32'h0, 4'h0, 3, 1'b0, 1'b0);
        txn("t4.misaligned", 32'h12, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        txn("t4.past_end", BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 1'b0);
        txn("t4.reread", 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        chk("t4.value", mem_rdata, 32'hDEAD_AAEF);

        mem_addr  = 32'h10;
        mem_wdata = 32'h1234_5678;
        mem_b_en  = 4'hF;
        cfg_wait  = WAIT_W'(5);
        mem_c_en  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        pulse_reset("t5.reset");
        txn("t5.read", 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        chk("t5.value", mem_rdata, 32'hDEAD_AAEF);

        txn("t6.write", 32'h20, 32'hCAFE_F00D, 4'hF, 1, 1'b1, 1'b0);
        txn("t6.read",  32'h20, 32'h0,         4'h0, 1, 1'b0, 1'b0);
        chk("t6.value", mem_rdata, 32'hCAFE_F00D);
        txn("drop.write", 32'h24, 32'h5A5A_A5A5, 4'hF, 2, 1'b0, 1'b1);
        txn("drop.read",  32'h24, 32'h0,         4'h0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
            else if (r == 8) a = BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 15));
            else             a = 32'hFFFF_FFFC;
            b  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wt = $urandom_range(0, 4);
            txn("rand", a, $urandom, b, wt, 1'($urandom_range(0, 1)),
                (wt > 0) && ($urandom_range(0, 3) == 0));
        end
        if (in_resp) begin
            mem_c_en = 1'b0;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvm_mem_responder.md
Name: rvm_mem_responder

Overview:
- Memory-side responder for the core's single-port memory bus. It is the far end of the core's mem_addr / mem_rdata / mem_wdata / mem_c_en / mem_b_en / mem_error / mem_stall interface.
- Serves word reads and byte-enabled writes from an internal word array.
- Inserts a programmable number of wait states and flags bad addresses on mem_error.
- Used as the on-chip RAM model in system benches and as the RAM block in small SoC builds.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; word index is (mem_addr-BASE_ADDR)>>2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
WAIT_W, 4, width of cfg_wait.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
mem_addr  input  32  byte address from the core.
mem_wdata  input  32  write data; byte i is mem_wdata[8i+7:8i].
mem_c_en  input  1  request valid (chip enable).
mem_b_en  input  4  byte enables; 4'b0000 means read, any nonzero value means write of the enabled bytes.
cfg_wait  input  WAIT_W  number of extra wait cycles; sampled only when a request is accepted.
mem_rdata  output  32  read data; registered.
mem_error  output  1  access error; registered; valid only in the RESP cycle.
mem_stall  output  1  high while a request is in progress and not yet answered.

Behaviour:
- Reset, asynchronous on reset=1:
  - state=IDLE, wait counter=0, captured request cleared.
  - mem_rdata=0, mem_error=0, mem_stall=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP. One request is outstanding at most.
- IDLE:
  - When mem_c_en=1, the request is accepted.
  - mem_addr, mem_wdata, mem_b_en and cfg_wait are captured.
  - Next state is WAIT if cfg_wait>0, otherwise RESP.
- WAIT:
  - Counter loads cfg_wait-1 on entry and decrements each cycle.
  - Moves to RESP on the cycle the counter reads 0.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - The core samples mem_rdata and mem_error in this cycle.
- mem_stall is combinational: (state==IDLE && mem_c_en) || state==WAIT. It is 0 in RESP.
- Latency: an access occupies cfg_wait+2 cycles from acceptance to the end of RESP.
  - mem_stall is high for cfg_wait+1 cycles.
  - Minimum latency is 2 cycles (cfg_wait=0).
- Error condition, evaluated on the captured request: error if either holds:
  - addr[1:0]!=0 (misaligned), or
  - addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH.
- Read, no error: mem_rdata=array[index] and mem_error=0, both registered on the edge entering RESP.
- Write, no error:
  - Enabled bytes of array[index] are updated on the edge entering RESP; disabled bytes are kept.
  - mem_rdata is unchanged.
  - mem_error=0.
- Any error:
  - No array update.
  - mem_rdata=0, mem_error=1, both in the RESP cycle.
- mem_error returns to 0 on the edge leaving RESP.
- mem_rdata holds its last value until the next RESP.
- The core holds mem_c_en, mem_addr, mem_wdata and mem_b_en stable until it sees mem_stall=0. The responder ignores those inputs outside IDLE.
- mem_c_en=1 during RESP belongs to the finished request; it is not a new request.
- mem_c_en still 1 in the following IDLE cycle is a new request. Back-to-back requests therefore have one IDLE accept cycle between RESPs.
- If mem_c_en drops during WAIT, the responder still completes the access: a write commits and RESP occurs.
- Reset during WAIT: the access is abandoned and an uncommitted write never reaches the array.
- Reset asserted in the RESP cycle: any commit made on the RESP-entry edge stands.

Test Plan:
1. Write 32'hDEADBEEF to 0x10 with b_en=4'hF, cfg_wait=0, then read 0x10 -> each access has stall high for 1 cycle, then RESP with error=0; the read returns rdata=32'hDEADBEEF.
2. After test 1, write 32'h0000AA00 to 0x10 with b_en=4'b0010, then read 0x10 -> rdata=32'hDEADAAEF.
3. Read with cfg_wait=3 -> stall high for exactly 4 cycles; rdata valid and stall=0 in cycle 5; back in IDLE in cycle 6.
4. Error cases:
   - Read 0x12 -> error=1, rdata=0.
   - Write 0xFFFF_FFFF to BASE_ADDR+4*DEPTH -> error=1.
   - Re-read 0x10 -> still 32'hDEADAAEF.
5. Write 32'h12345678 to 0x10 with cfg_wait=5; assert reset for 1 cycle during WAIT -> stall=0, rdata=0, error=0 immediately; a following read of 0x10 returns 32'hDEADAAEF.
6. Hold c_en=1 across a write to 0x20 (cfg_wait=1) followed by a read of 0x20 -> second acceptance occurs in the IDLE cycle after the first RESP; the read returns the written data; no spurious error.
